// File: rtl/ra_remote_responder.sv
// Remote-access home-node responder: turns request flits into cache accesses and replies.
// Optional RA_WRITE_ACK_EN: acknowledge every write with a RESP flit carrying zero data.
module ra_remote_responder #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int VC_BITS      = 1,
    parameter int ID_BITS      = 4,
    parameter int EXTRA        = 2,
    parameter int TYPE_BITS    = 2,
    localparam int FLOW_BITS   = 2*ID_BITS+EXTRA,
    localparam int FLIT_WIDTH  = FLOW_BITS+TYPE_BITS+VC_BITS+DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [FLIT_WIDTH-1:0]   flit_in,
    input  logic                    v_flit_in,
    output logic                    in_ready,
    output logic                    net2cache_Read,
    output logic                    net2cache_Write,
    output logic [ADDRESS_BITS-1:0] net2cache_Addr,
    output logic [DATA_WIDTH-1:0]   net2cache_Data,
    input  logic [ADDRESS_BITS-1:0] cache2net_Addr,
    input  logic [DATA_WIDTH-1:0]   cache2net_Data,
    input  logic                    cache2net_Valid,
    input  logic                    cache2net_Ready,
    output logic [FLIT_WIDTH-1:0]   flit_out,
    output logic                    v_flit_out,
    input  logic                    out_ready,
    output logic [7:0]              drop_count
);

    localparam int VcLo    = DATA_WIDTH;
    localparam int TypeLo  = VcLo + VC_BITS;
    localparam int ExtraLo = TypeLo + TYPE_BITS;
    localparam int SrcLo   = ExtraLo + EXTRA;

    localparam logic [TYPE_BITS-1:0] TypeRdHead = TYPE_BITS'(0);
    localparam logic [TYPE_BITS-1:0] TypeWrHead = TYPE_BITS'(1);
    localparam logic [TYPE_BITS-1:0] TypeWrData = TYPE_BITS'(2);
    localparam logic [TYPE_BITS-1:0] TypeResp   = TYPE_BITS'(3);
    localparam logic [ID_BITS-1:0]   CoreId     = ID_BITS'(CORE);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        ISSUE,
        WAIT_CACHE,
        SEND
    } fsmState_t;

    fsmState_t state, nextState;

    logic [ID_BITS-1:0]      srcLatch;
    logic [VC_BITS-1:0]      vcLatch;
    logic [ADDRESS_BITS-1:0] addrLatch;
    logic [DATA_WIDTH-1:0]   dataLatch;
    logic                    opWrite;
    logic [FLIT_WIDTH-1:0]   respFlit;
    logic [7:0]              dropCount;

    logic [TYPE_BITS-1:0]  inType;
    logic [ID_BITS-1:0]    inSrc;
    logic [VC_BITS-1:0]    inVc;
    logic [DATA_WIDTH-1:0] inData;
    logic                  accept;

    logic                  latchHead;
    logic                  latchData;
    logic                  dropFlit;
    logic                  captureResp;
    logic [DATA_WIDTH-1:0] respData;
    logic                  rdStrobe;
    logic                  wrStrobe;
    logic                  unusedFlit;

    assign inType = flit_in[TypeLo +: TYPE_BITS];
    assign inSrc  = flit_in[SrcLo +: ID_BITS];
    assign inVc   = flit_in[VcLo +: VC_BITS];
    assign inData = flit_in[DATA_WIDTH-1:0];

    // DEST and EXTRA of incoming flits carry nothing the responder needs
    assign unusedFlit = ^flit_in;

    // Gated by reset so in_ready stays low while reset is held
    assign in_ready = reset && (state == IDLE || state == WAIT_DATA);
    assign accept   = v_flit_in && in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState   = state;
        latchHead   = 1'b0;
        latchData   = 1'b0;
        dropFlit    = 1'b0;
        captureResp = 1'b0;
        respData    = cache2net_Data;
        rdStrobe    = 1'b0;
        wrStrobe    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (inType == TypeRdHead) begin
                        latchHead = 1'b1;
                        nextState = ISSUE;
                    end else if (inType == TypeWrHead) begin
                        latchHead = 1'b1;
                        nextState = WAIT_DATA;
                    end else begin
                        dropFlit = 1'b1;
                    end
                end
            end
            WAIT_DATA: begin
                if (accept) begin
                    if (inType == TypeWrData && inSrc == srcLatch) begin
                        latchData = 1'b1;
                        nextState = ISSUE;
                    end else begin
                        dropFlit = 1'b1;
                    end
                end
            end
            ISSUE: begin
                rdStrobe = !opWrite && cache2net_Ready;
                wrStrobe = opWrite && cache2net_Ready;
                if (cache2net_Ready) begin
                    if (!opWrite) begin
                        nextState = WAIT_CACHE;
                    end else begin
`ifdef RA_WRITE_ACK_EN
                        captureResp = 1'b1;
                        respData    = '0;
                        nextState   = SEND;
`else
                        nextState   = IDLE;
`endif
                    end
                end
            end
            WAIT_CACHE: begin
                if (cache2net_Valid && cache2net_Addr == addrLatch) begin
                    captureResp = 1'b1;
                    nextState   = SEND;
                end
            end
            SEND: begin
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            srcLatch  <= '0;
            vcLatch   <= '0;
            addrLatch <= '0;
            dataLatch <= '0;
            opWrite   <= 1'b0;
            respFlit  <= '0;
            dropCount <= '0;
        end else begin
            if (latchHead) begin
                srcLatch  <= inSrc;
                vcLatch   <= inVc;
                addrLatch <= inData[ADDRESS_BITS-1:0];
                opWrite   <= (inType == TypeWrHead);
            end
            if (latchData) dataLatch <= inData;
            if (captureResp) begin
                respFlit <= {srcLatch, CoreId, {EXTRA{1'b0}},
                             TypeResp, vcLatch, respData};
            end
            if (dropFlit && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
        end
    end

    logic drivesCache;
    assign drivesCache = (state == ISSUE) || (state == WAIT_CACHE);

    assign net2cache_Read  = rdStrobe;
    assign net2cache_Write = wrStrobe;
    assign net2cache_Addr  = drivesCache ? addrLatch : '0;
    assign net2cache_Data  = drivesCache ? dataLatch : '0;
    assign v_flit_out      = (state == SEND);
    assign flit_out        = (state == SEND) ? respFlit : '0;
    assign drop_count      = dropCount;

endmodule

// File: tb/tb_ra_remote_responder.sv
// Scoreboard bench for ra_remote_responder: expected cache requests and
// response flits are queued by the stimulus and checked by a monitor.
module tb_ra_remote_responder;

    localparam int CORE = 6;
    localparam int FW   = 45;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [FW-1:0] flit_in = '0;
    logic          v_flit_in = 1'b0;
    logic          in_ready;
    logic          net2cache_Read;
    logic          net2cache_Write;
    logic [31:0]   net2cache_Addr;
    logic [31:0]   net2cache_Data;
    logic [31:0]   cache2net_Addr = '0;
    logic [31:0]   cache2net_Data = '0;
    logic          cache2net_Valid = 1'b0;
    logic          cache2net_Ready = 1'b1;
    logic [FW-1:0] flit_out;
    logic          v_flit_out;
    logic          out_ready = 1'b1;
    logic [7:0]    drop_count;

    ra_remote_responder #(.CORE(CORE)) dut (
        .clock(clock),
        .reset(reset),
        .flit_in(flit_in),
        .v_flit_in(v_flit_in),
        .in_ready(in_ready),
        .net2cache_Read(net2cache_Read),
        .net2cache_Write(net2cache_Write),
        .net2cache_Addr(net2cache_Addr),
        .net2cache_Data(net2cache_Data),
        .cache2net_Addr(cache2net_Addr),
        .cache2net_Data(cache2net_Data),
        .cache2net_Valid(cache2net_Valid),
        .cache2net_Ready(cache2net_Ready),
        .flit_out(flit_out),
        .v_flit_out(v_flit_out),
        .out_ready(out_ready),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cacheReq_t;

    cacheReq_t     reqQ[$];
    logic [FW-1:0] respQ[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [FW-1:0] mkFlit(input logic [3:0] dest,
                                            input logic [3:0] src,
                                            input logic [1:0] typ,
                                            input logic vc,
                                            input logic [31:0] data);
        return {dest, src, 2'b00, typ, vc, data};
    endfunction

    function automatic logic [FW-1:0] mkResp(input logic [3:0] dest,
                                            input logic vc,
                                            input logic [31:0] data);
        logic [3:0] coreId;
        coreId = 4'(CORE);
        return {dest, coreId, 2'b00, 2'd3, vc, data};
    endfunction

    function automatic cacheReq_t mkReq(input bit wr, input logic [31:0] addr,
                                        input logic [31:0] data);
        cacheReq_t r;
        r.wr = wr;
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe and every cycle of v_flit_out is matched
    // against the head of the corresponding queue
    always @(negedge clock) begin
        if (reset) begin
            if (net2cache_Read || net2cache_Write) begin
                checks++;
                if (reqQ.size() == 0) begin
                    errors++;
                    $display("FAIL cacheReq: unexpected strobe rd=%0b wr=%0b addr=%h",
                             net2cache_Read, net2cache_Write, net2cache_Addr);
                end else begin
                    cacheReq_t e;
                    e = reqQ.pop_front();
                    if (net2cache_Write !== e.wr || net2cache_Read !== !e.wr ||
                        net2cache_Addr !== e.addr ||
                        (e.wr && net2cache_Data !== e.data)) begin
                        errors++;
                        $display("FAIL cacheReq: got rd=%0b wr=%0b addr=%h data=%h expected wr=%0b addr=%h data=%h",
                                 net2cache_Read, net2cache_Write, net2cache_Addr,
                                 net2cache_Data, e.wr, e.addr, e.data);
                    end
                end
            end
            if (v_flit_out) begin
                checks++;
                if (respQ.size() == 0) begin
                    errors++;
                    $display("FAIL respFlit: unexpected flit %h", flit_out);
                end else begin
                    if (flit_out !== respQ[0]) begin
                        errors++;
                        $display("FAIL respFlit: got %h expected %h", flit_out, respQ[0]);
                    end
                    if (out_ready) void'(respQ.pop_front());
                end
            end
        end
    end

    task automatic sendFlit(input logic [FW-1:0] f);
        bit done;
        done = 0;
        flit_in = f;
        v_flit_in = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1;
            @(posedge clock);
            #1;
        end
        v_flit_in = 1'b0;
        flit_in = '0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL sendFlit: in_ready timeout got 0 expected 1");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((reqQ.size() != 0 || respQ.size() != 0) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (reqQ.size() != 0 || respQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending req=%0d resp=%0d expected 0",
                     reqQ.size(), respQ.size());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic reply(input logic [31:0] addr, input logic [31:0] data);
        cache2net_Valid = 1'b1;
        cache2net_Addr = addr;
        cache2net_Data = data;
        @(posedge clock);
        #1;
        cache2net_Valid = 1'b0;
        cache2net_Addr = '0;
        cache2net_Data = '0;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_v_flit_out", 64'(v_flit_out), 64'd0);
        chk("rst_flit_out", 64'(flit_out), 64'd0);
        chk("rst_strobes", 64'({net2cache_Read, net2cache_Write}), 64'd0);
        chk("rst_addr", 64'(net2cache_Addr), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;

        // read, L=2
        reqQ.push_back(mkReq(0, 32'h40, 32'h0));
        respQ.push_back(mkResp(4'd3, 1'b1, 32'hDEADBEEF));
        sendFlit(mkFlit(4'd0, 4'd3, 2'd0, 1'b1, 32'h40));
        chk("rd_issue_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reply(32'h40, 32'hDEADBEEF);
        chk("rd_v_after_reply", 64'(v_flit_out), 64'd1);
        chk("rd_send_in_ready", 64'(in_ready), 64'd0);
        drain();
        chk("rd_back_to_back_ready", 64'(in_ready), 64'd1);

        // write
        reqQ.push_back(mkReq(1, 32'h100, 32'h12345678));
`ifdef RA_WRITE_ACK_EN
        respQ.push_back(mkResp(4'd2, 1'b0, 32'h0));
`endif
        sendFlit(mkFlit(4'd0, 4'd2, 2'd1, 1'b0, 32'h100));
        sendFlit(mkFlit(4'd0, 4'd2, 2'd2, 1'b0, 32'h12345678));
        repeat (3) @(posedge clock);
        #1;
        drain();
        chk("wr_drop", 64'(drop_count), 64'd0);

        // backpressure on cache and router
        cache2net_Ready = 1'b0;
        reqQ.push_back(mkReq(0, 32'h200, 32'h0));
        respQ.push_back(mkResp(4'd1, 1'b0, 32'hCAFEF00D));
        sendFlit(mkFlit(4'd0, 4'd1, 2'd0, 1'b0, 32'h200));
        for (int i = 0; i < 5; i++) begin
            chk("bp_no_strobe", 64'(net2cache_Read), 64'd0);
            @(posedge clock);
            #1;
        end
        cache2net_Ready = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        reply(32'h200, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            chk("bp_v_held", 64'(v_flit_out), 64'd1);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        drain();
        chk("bp_single_xfer", 64'(v_flit_out), 64'd0);

        // protocol errors
        sendFlit(mkFlit(4'd0, 4'd1, 2'd2, 1'b0, 32'h99));
        sendFlit(mkFlit(4'd0, 4'd2, 2'd1, 1'b0, 32'h300));
        sendFlit(mkFlit(4'd0, 4'd5, 2'd2, 1'b0, 32'h77));
        chk("perr_drop2", 64'(drop_count), 64'd2);
        chk("perr_wait_data", 64'(in_ready), 64'd1);
        reqQ.push_back(mkReq(1, 32'h300, 32'h55));
`ifdef RA_WRITE_ACK_EN
        respQ.push_back(mkResp(4'd2, 1'b0, 32'h0));
`endif
        sendFlit(mkFlit(4'd0, 4'd2, 2'd2, 1'b0, 32'h55));
        drain();
        for (int i = 0; i < 253; i++) sendFlit(mkFlit(4'd0, 4'd1, 2'd3, 1'b0, 32'h1));
        chk("sat_reach", 64'(drop_count), 64'd255);
        for (int i = 0; i < 47; i++) sendFlit(mkFlit(4'd0, 4'd1, 2'd3, 1'b0, 32'h1));
        chk("sat_hold", 64'(drop_count), 64'd255);

        // reply filtering
        reqQ.push_back(mkReq(0, 32'h40, 32'h0));
        respQ.push_back(mkResp(4'd7, 1'b0, 32'h0000600D));
        sendFlit(mkFlit(4'd0, 4'd7, 2'd0, 1'b0, 32'h40));
        @(posedge clock);
        #1;
        reply(32'h44, 32'h00000BAD);
        chk("filt_no_capture", 64'(v_flit_out), 64'd0);
        reply(32'h40, 32'h0000600D);
        drain();

        // reset during WAIT_CACHE
        reqQ.push_back(mkReq(0, 32'h80, 32'h0));
        sendFlit(mkFlit(4'd0, 4'd4, 2'd0, 1'b1, 32'h80));
        @(posedge clock);
        #1;
        chk("mid_addr", 64'(net2cache_Addr), 64'h80);
        reset = 1'b0;
        #1;
        chk("mid_rst_addr", 64'(net2cache_Addr), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_v", 64'(v_flit_out), 64'd0);
        chk("mid_rst_drop", 64'(drop_count), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        reply(32'h80, 32'h11111111);
        reqQ.push_back(mkReq(0, 32'h40, 32'h0));
        respQ.push_back(mkResp(4'd4, 1'b1, 32'h0BADCAFE));
        sendFlit(mkFlit(4'd0, 4'd4, 2'd0, 1'b1, 32'h40));
        @(posedge clock);
        #1;
        reply(32'h40, 32'h0BADCAFE);
        drain();

        repeat (3) @(posedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
